// File: rtl/oc_pkg.sv
// Shared definitions for the ones-counter frame accumulator.
//   oc_acc_state_t : accumulator FSM encoding (IDLE, ACC, HOLD)
//   OC_CNT_MAX     : largest value the 2-bit ones-count can take
//   oc_sum_w()     : sum width needed to hold 3*frame_len without saturating
package oc_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    ACC  = 2'd1,
    HOLD = 2'd2
  } oc_acc_state_t;

  localparam logic [1:0] OC_CNT_MAX = 2'd3;

  function automatic int oc_sum_w(input int frame_len);
    return $clog2(3 * frame_len + 1);
  endfunction

endpackage

// File: rtl/oc_sat_add.sv
// Saturating unsigned adder: sum = min(a + inc, 2^W-1).
// Ports:
//   a   in  W  accumulator value
//   inc in  2  increment (a ones-count, 0..3)
//   sum out W  saturated result
// W must be at least 2.
module oc_sat_add #(
  parameter int W = 5
) (
  input  logic [W-1:0] a,
  input  logic [1:0]   inc,
  output logic [W-1:0] sum
);

  logic [W:0] wide;

  // One extra bit catches the carry; any carry means the true sum no longer fits.
  assign wide = {1'b0, a} + {{(W - 1){1'b0}}, inc};
  assign sum  = wide[W] ? {W{1'b1}} : wide[W-1:0];

endmodule

// File: rtl/oc_frame_accumulator.sv
// Frame accumulator for the 3-input ones-counter stream.
// Collects FRAME_LEN accepted 2-bit counts {y1,y0} and presents the frame sum
// (saturating), the maximum count and the number of count==3 samples on a
// valid/ready result port.
// Ports:
//   clk, rst              clock, synchronous active-high reset
//   start                 one-cycle pulse: begin (or restart) a frame
//   in_valid, y1, y0      sample stream; in_ready high only while accumulating
//   out_valid, out_ready  result handshake
//   sum_out, max_out, ones3_out   frame results, held until the next start
//   hist0_out..hist3_out  per-count histogram (zero unless OC_ACC_HIST_EN)
//   fsm_state             current FSM state, for observation only
// Configuration macro: OC_ACC_HIST_EN enables the histogram counters.
//
// Handshakes: a sample transfers on a cycle where in_valid && in_ready and no
// start is present; a result transfers on a cycle where out_valid && out_ready.
// out_valid, once high, stays high with stable data until that transfer.
module oc_frame_accumulator
  import oc_pkg::*;
#(
  parameter int FRAME_LEN = 8,
  parameter int SUM_W     = 5,
  parameter int CNT_W     = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic             in_valid,
  input  logic             y1,
  input  logic             y0,
  output logic             in_ready,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [SUM_W-1:0] sum_out,
  output logic [1:0]       max_out,
  output logic [CNT_W-1:0] ones3_out,
  output logic [CNT_W-1:0] hist0_out,
  output logic [CNT_W-1:0] hist1_out,
  output logic [CNT_W-1:0] hist2_out,
  output logic [CNT_W-1:0] hist3_out,
  output logic [1:0]       fsm_state
);

  oc_acc_state_t    state_q, state_d;
  logic             clear;
  logic             accept;
  logic             last;
  logic [1:0]       sample;
  logic [SUM_W-1:0] sum_q, sum_next;
  logic [1:0]       max_q;
  logic [CNT_W-1:0] ones3_q;
  logic [CNT_W-1:0] cnt_q;

  assign sample = {y1, y0};
  assign last   = (cnt_q == CNT_W'(FRAME_LEN - 1));

  // ---------------- FSM ----------------
  always_ff @(posedge clk) begin
    if (rst) state_q <= IDLE;
    else     state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    clear   = 1'b0;
    accept  = 1'b0;
    case (state_q)
      IDLE: begin
        if (start) begin
          state_d = ACC;
          clear   = 1'b1;
        end
      end
      ACC: begin
        // A restart wins over a coincident sample: the sample is dropped.
        if (start) begin
          clear = 1'b1;
        end else if (in_valid) begin
          accept = 1'b1;
          if (last) state_d = HOLD;
        end
      end
      HOLD: begin
        // start is deliberately ignored here, even on the accept cycle.
        if (out_ready) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  assign in_ready  = (state_q == ACC);
  assign out_valid = (state_q == HOLD);
  assign fsm_state = state_q;

  // ---------------- datapath ----------------
  oc_sat_add #(.W(SUM_W)) u_sum_add (
    .a   (sum_q),
    .inc (sample),
    .sum (sum_next)
  );

  always_ff @(posedge clk) begin
    if (rst || clear) begin
      sum_q   <= '0;
      max_q   <= '0;
      ones3_q <= '0;
      cnt_q   <= '0;
    end else if (accept) begin
      sum_q   <= sum_next;
      cnt_q   <= cnt_q + 1'b1;
      if (sample > max_q)        max_q   <= sample;
      if (sample == OC_CNT_MAX)  ones3_q <= ones3_q + 1'b1;
    end
  end

  assign sum_out   = sum_q;
  assign max_out   = max_q;
  assign ones3_out = ones3_q;

`ifdef OC_ACC_HIST_EN
  logic [CNT_W-1:0] hist_q [4];

  always_ff @(posedge clk) begin
    if (rst || clear) begin
      for (int i = 0; i < 4; i++) hist_q[i] <= '0;
    end else if (accept) begin
      hist_q[sample] <= hist_q[sample] + 1'b1;
    end
  end

  assign hist0_out = hist_q[0];
  assign hist1_out = hist_q[1];
  assign hist2_out = hist_q[2];
  assign hist3_out = hist_q[3];
`else
  assign hist0_out = '0;
  assign hist1_out = '0;
  assign hist2_out = '0;
  assign hist3_out = '0;
`endif

endmodule

// File: tb/tb_oc_frame_accumulator.sv
// Directed bench for oc_frame_accumulator. Three instances share one input
// stream: the default build (a), a 4-bit sum build that must saturate (s),
// and a FRAME_LEN=1 build (f1).
module tb_oc_frame_accumulator;

  logic clk = 1'b0;
  logic rst, start, in_valid, y1, y0, out_ready;

  logic       a_in_ready, a_out_valid;
  logic [4:0] a_sum;
  logic [1:0] a_max, a_state;
  logic [3:0] a_ones3, a_h0, a_h1, a_h2, a_h3;

  logic       s_in_ready, s_out_valid;
  logic [3:0] s_sum;
  logic [1:0] s_max, s_state;
  logic [3:0] s_ones3, s_h0, s_h1, s_h2, s_h3;

  logic       f_in_ready, f_out_valid;
  logic [4:0] f_sum;
  logic [1:0] f_max, f_state;
  logic [3:0] f_ones3, f_h0, f_h1, f_h2, f_h3;

  int pass_cnt  = 0;
  int total_cnt = 0;

  // ---------------- clock ----------------
  always #5 clk = ~clk;

  // ---------------- DUTs ----------------
  oc_frame_accumulator #(.FRAME_LEN(8), .SUM_W(5), .CNT_W(4)) dut_a (
    .clk(clk), .rst(rst), .start(start), .in_valid(in_valid), .y1(y1), .y0(y0),
    .in_ready(a_in_ready), .out_valid(a_out_valid), .out_ready(out_ready),
    .sum_out(a_sum), .max_out(a_max), .ones3_out(a_ones3),
    .hist0_out(a_h0), .hist1_out(a_h1), .hist2_out(a_h2), .hist3_out(a_h3),
    .fsm_state(a_state)
  );

  oc_frame_accumulator #(.FRAME_LEN(8), .SUM_W(4), .CNT_W(4)) dut_s (
    .clk(clk), .rst(rst), .start(start), .in_valid(in_valid), .y1(y1), .y0(y0),
    .in_ready(s_in_ready), .out_valid(s_out_valid), .out_ready(out_ready),
    .sum_out(s_sum), .max_out(s_max), .ones3_out(s_ones3),
    .hist0_out(s_h0), .hist1_out(s_h1), .hist2_out(s_h2), .hist3_out(s_h3),
    .fsm_state(s_state)
  );

  oc_frame_accumulator #(.FRAME_LEN(1), .SUM_W(5), .CNT_W(4)) dut_f1 (
    .clk(clk), .rst(rst), .start(start), .in_valid(in_valid), .y1(y1), .y0(y0),
    .in_ready(f_in_ready), .out_valid(f_out_valid), .out_ready(out_ready),
    .sum_out(f_sum), .max_out(f_max), .ones3_out(f_ones3),
    .hist0_out(f_h0), .hist1_out(f_h1), .hist2_out(f_h2), .hist3_out(f_h3),
    .fsm_state(f_state)
  );

  // ---------------- driver tasks ----------------
  // Advance one clock; inputs change and outputs are sampled 1 ns after the edge.
  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic drive_sample(input logic v, input logic [1:0] c);
    in_valid = v;
    {y1, y0} = c;
    cyc();
  endtask

  task automatic pulse_start();
    start = 1'b1;
    cyc();
    start = 1'b0;
  endtask

  task automatic release_result();
    out_ready = 1'b1;
    cyc();
    out_ready = 1'b0;
  endtask

  // ---------------- tests ----------------
  task automatic test_reset();
    rst = 1'b1; start = 1'b0; in_valid = 1'b0; {y1, y0} = 2'd0; out_ready = 1'b0;
    cyc(); cyc();
    rst = 1'b0;
    total_cnt++;
    if ({a_out_valid, a_in_ready, a_sum, a_max, a_ones3, a_state} !== 15'd0) $display("FAIL reset_a: got ov=%b ir=%b sum=%0d max=%0d o3=%0d st=%0d, want all 0", a_out_valid, a_in_ready, a_sum, a_max, a_ones3, a_state);
    else pass_cnt++;
    total_cnt++;
    if ({a_h0, a_h1, a_h2, a_h3} !== 16'd0) $display("FAIL reset_hist: got %0d %0d %0d %0d, want 0 0 0 0", a_h0, a_h1, a_h2, a_h3);
    else pass_cnt++;
    total_cnt++;
    if ({s_out_valid, s_in_ready, s_sum, f_out_valid, f_in_ready, f_sum} !== 13'd0) $display("FAIL reset_sf: got s_ov=%b s_sum=%0d f_ov=%b f_sum=%0d, want 0", s_out_valid, s_sum, f_out_valid, f_sum);
    else pass_cnt++;
  endtask

  task automatic test_full_sweep();
    logic [2:0] bits;
    logic [1:0] cnt;
    pulse_start();
    total_cnt++;
    if (a_in_ready !== 1'b1 || a_state !== 2'd1) $display("FAIL sweep_acc: got ir=%b st=%0d, want ir=1 st=1", a_in_ready, a_state);
    else pass_cnt++;
    for (int i = 0; i < 8; i++) begin
      bits = 3'(i);
      cnt  = 2'(bits[0]) + 2'(bits[1]) + 2'(bits[2]);
      drive_sample(1'b1, cnt);
      if (i == 0) begin
        total_cnt++;
        if (f_out_valid !== 1'b1 || f_sum !== 5'd0 || f_in_ready !== 1'b0) $display("FAIL frame_len1: got ov=%b sum=%0d ir=%b, want ov=1 sum=0 ir=0", f_out_valid, f_sum, f_in_ready);
        else pass_cnt++;
      end
      if (i == 6) begin
        total_cnt++;
        if (a_out_valid !== 1'b0) $display("FAIL sweep_early: got out_valid=%b after 7 samples, want 0", a_out_valid);
        else pass_cnt++;
      end
    end
    in_valid = 1'b0;
    total_cnt++;
    if (a_out_valid !== 1'b1 || a_in_ready !== 1'b0) $display("FAIL sweep_latency: got ov=%b ir=%b, want ov=1 ir=0", a_out_valid, a_in_ready);
    else pass_cnt++;
    total_cnt++;
    if (a_sum !== 5'd12 || a_max !== 2'd3 || a_ones3 !== 4'd1) $display("FAIL sweep_result: got sum=%0d max=%0d o3=%0d, want 12 3 1", a_sum, a_max, a_ones3);
    else pass_cnt++;
    total_cnt++;
    if (f_sum !== 5'd0 || f_max !== 2'd0) $display("FAIL frame_len1_hold: got sum=%0d max=%0d, want 0 0", f_sum, f_max);
    else pass_cnt++;
    total_cnt++;
`ifdef OC_ACC_HIST_EN
    if ({a_h0, a_h1, a_h2, a_h3} !== {4'd1, 4'd3, 4'd3, 4'd1}) $display("FAIL sweep_hist: got %0d %0d %0d %0d, want 1 3 3 1", a_h0, a_h1, a_h2, a_h3);
`else
    if ({a_h0, a_h1, a_h2, a_h3} !== 16'd0) $display("FAIL sweep_hist_off: got %0d %0d %0d %0d, want 0 0 0 0", a_h0, a_h1, a_h2, a_h3);
`endif
    else pass_cnt++;
  endtask

  task automatic test_backpressure();
    out_ready = 1'b0;
    for (int i = 0; i < 5; i++) begin
      start = (i == 2);
      drive_sample(1'b1, 2'd3);
      total_cnt++;
      if (a_out_valid !== 1'b1 || a_in_ready !== 1'b0 || a_sum !== 5'd12 || a_max !== 2'd3 || a_ones3 !== 4'd1)
        $display("FAIL bp_hold_%0d: got ov=%b ir=%b sum=%0d max=%0d o3=%0d, want 1 0 12 3 1", i, a_out_valid, a_in_ready, a_sum, a_max, a_ones3);
      else pass_cnt++;
    end
    // Accept with a coincident start: must still land in IDLE.
    start = 1'b1;
    release_result();
    start = 1'b0;
    total_cnt++;
    if (a_out_valid !== 1'b0 || a_state !== 2'd0 || a_sum !== 5'd12) $display("FAIL bp_release: got ov=%b st=%0d sum=%0d, want 0 0 12", a_out_valid, a_state, a_sum);
    else pass_cnt++;
    // Samples and out_ready in IDLE have no effect.
    out_ready = 1'b1;
    for (int i = 0; i < 3; i++) drive_sample(1'b1, 2'd3);
    out_ready = 1'b0;
    in_valid  = 1'b0;
    total_cnt++;
    if (a_state !== 2'd0 || a_in_ready !== 1'b0 || a_sum !== 5'd12 || a_ones3 !== 4'd1) $display("FAIL idle_ignore: got st=%0d ir=%b sum=%0d o3=%0d, want 0 0 12 1", a_state, a_in_ready, a_sum, a_ones3);
    else pass_cnt++;
  endtask

  task automatic test_gapped();
    pulse_start();
    for (int k = 0; k < 15; k++) begin
      drive_sample((k % 2) == 0, 2'd2);
      if (k == 7) begin
        total_cnt++;
        if (a_out_valid !== 1'b0) $display("FAIL gap_early: got out_valid=%b after 8 cycles, want 0", a_out_valid);
        else pass_cnt++;
      end
    end
    in_valid = 1'b0;
    total_cnt++;
    if (a_out_valid !== 1'b1 || a_sum !== 5'd16 || a_max !== 2'd2 || a_ones3 !== 4'd0) $display("FAIL gap_result: got ov=%b sum=%0d max=%0d o3=%0d, want 1 16 2 0", a_out_valid, a_sum, a_max, a_ones3);
    else pass_cnt++;
    release_result();
  endtask

  task automatic test_saturation();
    pulse_start();
    for (int i = 0; i < 8; i++) drive_sample(1'b1, 2'd3);
    in_valid = 1'b0;
    total_cnt++;
    if (s_out_valid !== 1'b1 || s_sum !== 4'd15 || s_ones3 !== 4'd8) $display("FAIL sat_result: got ov=%b sum=%0d o3=%0d, want 1 15 8", s_out_valid, s_sum, s_ones3);
    else pass_cnt++;
    total_cnt++;
    if (a_sum !== 5'd24 || a_ones3 !== 4'd8 || a_max !== 2'd3) $display("FAIL nosat_result: got sum=%0d o3=%0d max=%0d, want 24 8 3", a_sum, a_ones3, a_max);
    else pass_cnt++;
`ifdef OC_ACC_HIST_EN
    total_cnt++;
    if ({a_h0, a_h1, a_h2, a_h3} !== {4'd0, 4'd0, 4'd0, 4'd8}) $display("FAIL sat_hist: got %0d %0d %0d %0d, want 0 0 0 8", a_h0, a_h1, a_h2, a_h3);
    else pass_cnt++;
`endif
    release_result();
  endtask

  task automatic test_restart();
    pulse_start();
    for (int i = 0; i < 3; i++) drive_sample(1'b1, 2'd3);
    // Restart with a sample on the same cycle: that sample is dropped.
    start = 1'b1;
    drive_sample(1'b1, 2'd3);
    start = 1'b0;
    total_cnt++;
    if (a_sum !== 5'd0 || a_ones3 !== 4'd0 || a_state !== 2'd1) $display("FAIL restart_clear: got sum=%0d o3=%0d st=%0d, want 0 0 1", a_sum, a_ones3, a_state);
    else pass_cnt++;
    for (int i = 0; i < 8; i++) begin
      drive_sample(1'b1, 2'd1);
      if (i == 6) begin
        total_cnt++;
        if (a_out_valid !== 1'b0) $display("FAIL restart_early: got out_valid=%b after 7 samples, want 0", a_out_valid);
        else pass_cnt++;
      end
    end
    in_valid = 1'b0;
    total_cnt++;
    if (a_out_valid !== 1'b1 || a_sum !== 5'd8 || a_max !== 2'd1 || a_ones3 !== 4'd0) $display("FAIL restart_result: got ov=%b sum=%0d max=%0d o3=%0d, want 1 8 1 0", a_out_valid, a_sum, a_max, a_ones3);
    else pass_cnt++;
    release_result();
  endtask

  task automatic test_reset_mid();
    pulse_start();
    for (int i = 0; i < 4; i++) drive_sample(1'b1, 2'd2);
    in_valid = 1'b0;
    rst = 1'b1;
    cyc();
    rst = 1'b0;
    total_cnt++;
    if ({a_out_valid, a_in_ready, a_sum, a_max, a_ones3, a_state} !== 15'd0 || {a_h0, a_h1, a_h2, a_h3} !== 16'd0)
      $display("FAIL reset_mid: got ov=%b ir=%b sum=%0d max=%0d o3=%0d st=%0d h2=%0d, want all 0", a_out_valid, a_in_ready, a_sum, a_max, a_ones3, a_state, a_h2);
    else pass_cnt++;
    for (int i = 0; i < 9; i++) drive_sample(1'b1, 2'd3);
    in_valid = 1'b0;
    total_cnt++;
    if (a_out_valid !== 1'b0 || a_in_ready !== 1'b0 || a_sum !== 5'd0) $display("FAIL no_start: got ov=%b ir=%b sum=%0d, want 0 0 0", a_out_valid, a_in_ready, a_sum);
    else pass_cnt++;
  endtask

  // ---------------- sequence + report ----------------
  initial begin
    test_reset();
    test_full_sweep();
    test_backpressure();
    test_gapped();
    test_saturation();
    test_restart();
    test_reset_mid();
    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule
